// File: rtl/burst_driver.sv
// Burst initiator: clear pulse, len enable pulses with optional gaps, then timed wait for g_in; first x_out 2 cycles after start.
// Define BURST_DRIVER_PULSE_COUNT_EN to add the 'sent' pulse-count output; start is ignored while busy.
module burst_driver #(
   parameter int WIDTH   = 4,
   parameter int GAP     = 0,
   parameter int TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] len,
   output logic             s_out,
   output logic             x_out,
   input  logic             g_in,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef BURST_DRIVER_PULSE_COUNT_EN
   ,
   output logic [WIDTH-1:0] sent
`endif
);

   localparam int MAXC = (GAP > TIMEOUT) ? GAP : TIMEOUT;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP == 0) ? 0 : GAP - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_DRIVE, S_GAP, S_WAIT, S_DONE, S_ERR
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] rem_q;
   logic [CW-1:0]    cnt_q;   // shared by GAP spacing and WAIT timeout
`ifdef BURST_DRIVER_PULSE_COUNT_EN
   logic [WIDTH-1:0] sent_q;
   assign sent = sent_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         s_out   <= 1'b0;
         x_out   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
`ifdef BURST_DRIVER_PULSE_COUNT_EN
         sent_q  <= '0;
`endif
      end else begin
         // Outputs are the registered decode of the state being entered.
         s_out <= 1'b0;
         x_out <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_CLEAR;
                  rem_q   <= len;
                  s_out   <= 1'b1;
                  busy    <= 1'b1;
`ifdef BURST_DRIVER_PULSE_COUNT_EN
                  sent_q  <= '0;
`endif
               end
            end
            S_CLEAR: begin
               cnt_q <= '0;
               if (rem_q != '0) begin
                  state_q <= S_DRIVE;
                  x_out   <= 1'b1;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_DRIVE: begin
               rem_q <= rem_q - WIDTH'(1);
               cnt_q <= '0;
`ifdef BURST_DRIVER_PULSE_COUNT_EN
               sent_q <= sent_q + WIDTH'(1);
`endif
               if (g_in) begin
                  state_q <= S_ERR;
                  err     <= 1'b1;
               end else if (rem_q == WIDTH'(1)) begin
                  state_q <= S_WAIT;
               end else if (GAP > 0) begin
                  state_q <= S_GAP;
               end else begin
                  x_out <= 1'b1;
               end
            end
            S_GAP: begin
               if (g_in) begin
                  state_q <= S_ERR;
                  err     <= 1'b1;
               end else if (cnt_q == GAP_LAST) begin
                  state_q <= S_DRIVE;
                  x_out   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_WAIT: begin
               // g_in is checked first so it wins on the expiry cycle
               if (g_in) begin
                  state_q <= S_DONE;
                  done    <= 1'b1;
               end else if (cnt_q == TO_LAST) begin
                  state_q <= S_ERR;
                  err     <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DONE, S_ERR: begin
               state_q <= S_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/burst_driver.md
Name: burst_driver

Overview:
- Initiator for the count-until-saturate handshake used by the counter/control datapath.
- On a start request it performs three steps:
  - issues a one-cycle clear pulse (s_out);
  - drives x_out high for a programmed number of enable cycles, optionally separated by idle gaps;
  - waits for the completion flag g_in, with a timeout.
- Reports the result as done or err.
- Sits on the stimulus side, directly facing the counter block's s/x inputs and g output.

Parameters:
- WIDTH, 4, width of len and internal pulse counter; a full burst is 2^WIDTH-1 pulses.
- GAP, 0, idle cycles with x_out low inserted between consecutive x_out pulses (0 = back-to-back).
- TIMEOUT, 8, maximum cycles spent in WAIT for g_in before flagging err; must be >= 1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- len  input  WIDTH  number of x_out pulses; captured when start is accepted.
- s_out  output  1  clear pulse to the counter, exactly one cycle.
- x_out  output  1  count-enable to the counter.
- g_in  input  1  completion flag from the counter.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse: burst completed and g_in seen.
- err  output  1  one-cycle pulse: timeout in WAIT, or g_in high during DRIVE/GAP.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. Reset dominates everything, in any state including mid-burst. After reset:
  - state = IDLE;
  - s_out = x_out = busy = done = err = 0;
  - pulse and timeout counters = 0.
- All outputs are registered (Moore): each output reflects the current state, no combinational path from inputs.
- IDLE:
  - start=1 -> capture len into rem, go to CLEAR.
  - start=0 -> stay.
  - start asserted while busy is ignored (not queued).
- CLEAR: s_out=1 for one cycle. Next state: rem!=0 -> DRIVE; rem==0 -> WAIT.
- DRIVE: x_out=1 for one cycle, rem decrements. Next state:
  - rem reaches 0 -> WAIT;
  - else GAP>0 -> GAP;
  - else stay in DRIVE.
- GAP: x_out=0 for exactly GAP cycles, then back to DRIVE.
- Early flag: g_in=1 sampled in DRIVE or GAP -> go to ERR immediately. The current x_out pulse is not extended.
- WAIT: x_out=0; timeout counter starts at 0 on entry.
  - g_in=1 -> DONE.
  - g_in still 0 after TIMEOUT cycles in WAIT -> ERR.
  - g_in rising on the same cycle the timeout expires -> DONE (g_in wins).
- DONE: done=1 for one cycle -> IDLE.
- ERR: err=1 for one cycle -> IDLE.
- done and err are never high together.
- busy=1 from CLEAR through DONE/ERR inclusive.
- Latency, start accepted to first x_out high: 2 cycles (IDLE->CLEAR->DRIVE).
- Total x_out high cycles per burst = captured len exactly. len changes after capture have no effect.
- len = 2^WIDTH-1 (all ones) drives the downstream counter to saturation, so g is expected in WAIT.

Optional Feature:
- Macro: BURST_DRIVER_PULSE_COUNT_EN.
- Defined:
  - extra output port sent [WIDTH-1:0], counting x_out high cycles in the current burst;
  - cleared in CLEAR and on reset;
  - holds its final value in IDLE until the next accepted start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-DRIVE (len=10, reset asserted after 4th x_out pulse) -> next cycle all outputs 0, busy=0; a new start then yields a full 10-pulse burst.
- GAP=0, start with len=15, downstream counter model asserts g on reaching 15 -> s_out one cycle; x_out high exactly 15 consecutive cycles starting 2 cycles after start; done pulses once; err=0.
- GAP=2, len=3 -> x_out pattern 1,0,0,1,0,0,1 then WAIT; g_in driven high 3 cycles later -> done=1.
- len=0 -> CLEAR then WAIT with x_out never high; g_in held 0 -> err pulses after exactly TIMEOUT=8 WAIT cycles.
- g_in forced high during DRIVE (len=8, after pulse 3) -> err next cycle; x_out total 3 or 4 pulses, never more; then IDLE.
- start held high continuously -> the second burst begins only after DONE/ERR returns to IDLE. With BURST_DRIVER_PULSE_COUNT_EN defined, sent equals len after each burst.
